id_ex_stage_reg: RTL
====================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register (pipeline register 2) with integrated load-use hazard control.
//  - Captures decoded operands, register numbers and control bits from ID.
//  - Presents rs/rt to the forwarding unit, and the destination/write controls to EX/MEM.
//  - Detects load-use hazards, holds PC and IF/ID through the stall output, and inserts
//    bubbles into EX.
//  - Kills the ID instruction on a branch/jump flush.
// PARAMETERS
//  DATA_W        32  operand/immediate width
//  STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7)
//  PERF_W        16  width of saturating bubble counter
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       synchronous, active-high
//  id_valid       in   1       ID holds a real instruction
//  id_rs          in   5       source reg 1 number
//  id_rt          in   5       source reg 2 number
//  id_rd          in   5       rd field
//  id_uses_rt     in   1       rt is read as a source (R-type, store, branch)
//  id_reg_dst     in   1       1: dest = rd, 0: dest = rt
//  id_reg_write   in   1       write-back enable
//  id_mem_read    in   1       load
//  id_mem_write   in   1       store
//  id_mem_to_reg  in   1       WB selects memory data
//  id_alu_src     in   1       ALU B = immediate
//  id_alu_op      in   4       ALU operation
//  id_rdata1      in   DATA_W  register file port 1
//  id_rdata2      in   DATA_W  register file port 2
//  id_imm         in   DATA_W  sign-extended immediate
//  flush          in   1       branch/jump taken; kill ID instruction
//  stall          out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid, ex_rs, ex_rt, ex_dest(5), ex_reg_write, ex_mem_read, ex_mem_write,
//  ex_mem_to_reg, ex_alu_src, ex_alu_op, ex_rdata1, ex_rdata2, ex_imm
//                 out  -       registered copies; ex_dest = id_reg_dst ? id_rd : id_rt
//  bubble_count   out  PERF_W  saturating count of inserted bubbles
// BEHAVIOUR
//  - Reset: all ex_* outputs = 0, bubble_count = 0, state = RUN, cnt = 0.
//    stall = 0 in the reset cycle.
//  - Latency: one cycle. ID values sampled at edge N appear on ex_* after edge N.
//  - Bubble: all ex_* = 0. This includes ex_valid, ex_reg_write, ex_mem_read,
//    ex_mem_write, ex_rs, ex_rt and ex_dest.
//  - hazard (combinational) = id_valid & ex_mem_read & (ex_dest != 0) &
//    ((id_rs == ex_dest) | (id_uses_rt & (id_rt == ex_dest))).
//  - Rule 1: in RUN with no hazard and no flush, at the edge load ID (ex_valid = id_valid).
//  - Rule 2: in RUN with hazard and no flush:
//    - stall = 1; at the edge load a bubble; bubble_count++.
//    - If STALL_CYCLES > 1, go to STALL with cnt = STALL_CYCLES-1.
//    - Otherwise stay in RUN; the hazard clears because the load has left EX.
//  - Rule 3: in STALL:
//    - stall = 1; at each edge load a bubble, bubble_count++, cnt--.
//    - When cnt == 1 at the edge, go to RUN. The held ID instruction loads at the next edge.
//    - The upstream stages guarantee that id_* is held constant while stall = 1.
//  - Rule 4: flush (any state) has priority over hazard and stall.
//    - stall = 0 that cycle; at the edge load a bubble; state = RUN; cnt = 0.
//    - bubble_count does NOT increment on flush bubbles.
//  - Total bubbles per load-use = STALL_CYCLES. There is no stall if the load's dest is $0,
//    or if only rt matches and id_uses_rt = 0.
//  - bubble_count saturates at all-ones and never wraps.
//  - Rule 5: reset asserted mid-stall wins over everything at that edge. State returns to
//    RUN with reset values.
//  - There are no combinational paths from id_* data to ex_*; only stall is combinational.
// TESTING
//  1. reset=1 for 2 cycles -> all ex_* = 0, stall = 0, bubble_count = 0.
//  2. Load into EX (ex_mem_read=1, ex_dest=8); then ID add with id_rs=8 ->
//     - stall=1 for 1 cycle; ex_valid=0 for 1 cycle;
//     - the add appears in EX the following cycle; bubble_count=1.
//  3. Load with ex_dest=0 followed by id_rs=0 -> no stall.
//     Load with ex_dest=9 followed by id_rt=9, id_uses_rt=0 -> no stall.
//  4. Hazard and flush in the same cycle -> stall=0; bubble loaded; bubble_count unchanged;
//     the next ID instruction loads normally.
//  5. STALL_CYCLES=3, load-use on rt (id_uses_rt=1) -> stall high 3 consecutive cycles;
//     3 bubbles; bubble_count=3; then the instruction issues.
//  6. STALL_CYCLES=3, reset asserted on the 2nd stall cycle -> next cycle all ex_*=0,
//     stall=0, bubble_count=0.

Source files
------------

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX bundle: decoded ID fields in, registered EX copies out.
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rt;
    logic              id_reg_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_mem_to_reg;
    logic              id_alu_src;
    logic [3:0]        id_alu_op;
    logic [DATA_W-1:0] id_rdata1;
    logic [DATA_W-1:0] id_rdata2;
    logic [DATA_W-1:0] id_imm;

    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dest;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_rdata1;
    logic [DATA_W-1:0] ex_rdata2;
    logic [DATA_W-1:0] ex_imm;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_reg_dst,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        output id_alu_src, id_alu_op, id_rdata1, id_rdata2, id_imm,
        input  ex_valid, ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
        input  ex_rdata1, ex_rdata2, ex_imm
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_reg_dst,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        input  id_alu_src, id_alu_op, id_rdata1, id_rdata2, id_imm,
        output ex_valid, ex_rs, ex_rt, ex_dest, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_alu_op,
        output ex_rdata1, ex_rdata2, ex_imm
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall control,
// flush-to-bubble and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              stall,
    output logic [PERF_W-1:0] bubble_count,
    id_ex_stage_reg_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_op;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
    } ex_t;

    typedef enum logic {S_RUN, S_STALL} state_e;

    localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

    ex_t               ex_q, ex_d, id_pkt;
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] bc_q, bc_d;
    logic              hazard, in_stall, stall_raw, bc_inc;

    always_comb begin
        id_pkt.valid      = bus.id_valid;
        id_pkt.rs         = bus.id_rs;
        id_pkt.rt         = bus.id_rt;
        id_pkt.dest       = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        id_pkt.reg_write  = bus.id_reg_write;
        id_pkt.mem_read   = bus.id_mem_read;
        id_pkt.mem_write  = bus.id_mem_write;
        id_pkt.mem_to_reg = bus.id_mem_to_reg;
        id_pkt.alu_src    = bus.id_alu_src;
        id_pkt.alu_op     = bus.id_alu_op;
        id_pkt.rdata1     = bus.id_rdata1;
        id_pkt.rdata2     = bus.id_rdata2;
        id_pkt.imm        = bus.id_imm;
    end

    assign hazard = bus.id_valid & ex_q.mem_read & (ex_q.dest != 5'd0) &
                    ((bus.id_rs == ex_q.dest) |
                     (bus.id_uses_rt & (bus.id_rt == ex_q.dest)));

    assign in_stall = (state_q == S_STALL);

    // Flush outranks both the pending stall and a fresh hazard.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ex_d      = id_pkt;
        stall_raw = 1'b0;
        bc_inc    = 1'b0;
        unique case (1'b1)
            flush: begin
                ex_d    = '0;
                state_d = S_RUN;
                cnt_d   = '0;
            end
            !flush && in_stall: begin
                stall_raw = 1'b1;
                ex_d      = '0;
                bc_inc    = 1'b1;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = S_RUN;
            end
            !flush && !in_stall && hazard: begin
                stall_raw = 1'b1;
                ex_d      = '0;
                bc_inc    = 1'b1;
                if (STALL_CYCLES > 1) begin
                    state_d = S_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            default: ;
        endcase
    end

    assign bc_d  = (bc_inc && bc_q != '1) ? bc_q + 1'b1 : bc_q;
    assign stall = stall_raw & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            ex_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            bc_q    <= bc_d;
        end
    end

    assign bubble_count      = bc_q;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.ex_reg_write  = ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.mem_write;
    assign bus.ex_mem_to_reg = ex_q.mem_to_reg;
    assign bus.ex_alu_src    = ex_q.alu_src;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_rdata1     = ex_q.rdata1;
    assign bus.ex_rdata2     = ex_q.rdata2;
    assign bus.ex_imm        = ex_q.imm;
endmodule
